// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divide_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_next;
  logic                 is_div_q;
  logic                 neg_res;
  logic                 neg_rem;
  logic [WIDTH-1:0]     opnd_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic                 dz_pend;

  logic                 accept;
  logic                 dz_start;
  logic [WIDTH-1:0]     abs1;
  logic [WIDTH-1:0]     abs2;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // The skip cycle of a divide-by-zero also blocks a new start.
  always_comb begin
    accept   = (state == IDLE) && start && !flush && !dz_pend;
    dz_start = accept && op[1] && (op2 == '0);
    abs1     = op1;
    abs2     = op2;
    if (!op[0] && op1[WIDTH-1]) abs1 = -op1;
    if (!op[0] && op2[WIDTH-1]) abs2 = -op2;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : '0)};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_b};
    product  = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && !dz_start) state_next = RUN;
      RUN: begin
        if (flush)                 state_next = IDLE;
        else if (count == CW'(1))  state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      is_div_q    <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      opnd_b      <= '0;
      acc         <= '0;
      count       <= '0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      divide_zero <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != IDLE);
      done    <= 1'b0;
      dz_pend <= 1'b0;
      if (dz_pend) begin
        done        <= 1'b1;
        divide_zero <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            is_div_q    <= op[1];
            neg_res     <= !op[0] && (op1[WIDTH-1] ^ op2[WIDTH-1]);
            neg_rem     <= !op[0] && op[1] && op1[WIDTH-1];
            opnd_b      <= op[1] ? abs2 : abs1;
            acc         <= {{WIDTH{1'b0}}, (op[1] ? abs1 : abs2)};
            count       <= CW'(WIDTH);
            divide_zero <= 1'b0;
            dz_pend     <= dz_start;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (!flush) begin
            count <= count - CW'(1);
            if (!is_div_q)
              acc <= {mul_sum, acc[WIDTH-1:1]};
            else if (!div_diff[WIDTH])
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
              acc <= {acc[2*WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (is_div_q) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= product[2*WIDTH-1:WIDTH];
              lo <= product[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8)
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] op1, op2, wdata;
  logic        busy, done, divide_zero;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        zero8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .op1(op1), .op2(op2),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divide_zero(divide_zero)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .op1(a8), .op2(b8),
    .flush(zero8), .mthi(zero8), .mtlo(zero8), .wdata(wdata8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .divide_zero(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    sa = o[0] ? {32'b0, a} : longint'($signed(a));
    sb = o[0] ? {32'b0, b} : longint'($signed(b));
    if (!o[1]) begin
      p = sa * sb;
      m_hi = p[63:32];
      m_lo = p[31:0];
      m_dz = 1'b0;
    end else if (b == 32'd0) begin
      m_dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      m_dz = 1'b0;
    end
  endtask

  // Called at the negedge right after the start edge.
  task automatic finish_op(input string tag, input bit dz_case);
    int k, bc;
    k = 0;
    bc = 0;
    chk({tag, ".dz_cleared"}, divide_zero, 0);
    while (done !== 1'b1 && k < 80) begin
      if (busy === 1'b1) bc++;
      @(negedge clock);
      k++;
    end
    chk({tag, ".latency"}, k, dz_case ? 1 : 33);
    chk({tag, ".busy_cycles"}, bc, dz_case ? 0 : 33);
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
    chk({tag, ".divide_zero"}, divide_zero, m_dz);
    @(negedge clock);
    chk({tag, ".done_single"}, done, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    model(o, a, b);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(negedge clock);
    start = 1'b0;
    finish_op(tag, o[1] && (b == 32'd0));
  endtask

  task automatic write_hilo(input bit wh, input bit wl, input logic [31:0] d);
    mthi = wh; mtlo = wl; wdata = d;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("mtx.hi", hi, m_hi);
    chk("mtx.lo", lo, m_lo);
  endtask

  initial begin
    int k;
    bit saw_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; op1 = '0; op2 = '0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wdata8 = '0; zero8 = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;

    #3;
    chk("reset.hi", hi, 0);
    chk("reset.lo", lo, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.dz", divide_zero, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max.hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max.lo_const", lo, 32'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    chk("mult_neg.lo_const", lo, 32'hFFFF_FFF1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("div_neg.lo_const", lo, 32'hFFFF_FFFD);
    run_op("divu", 2'b11, 32'd7, 32'd2);
    chk("divu.hi_const", hi, 32'd1);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf.lo_const", lo, 32'h8000_0000);

    write_hilo(1, 1, 32'h0000_00CC);
    write_hilo(1, 0, 32'h0000_00AA);
    write_hilo(0, 1, 32'h0000_00BB);
    run_op("div_zero", 2'b10, 32'd5, 32'd0);
    chk("div_zero.hi_kept", hi, 32'hAA);
    run_op("divu_after_dz", 2'b11, 32'd9, 32'd4);

    // Flush in RUN cycle 10: no done, HI/LO retained.
    start = 1'b1; op = 2'b01; op1 = $urandom; op2 = $urandom;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush.busy", busy, 0);
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clock);
    end
    chk("flush.no_done", saw_done, 0);
    chk("flush.hi", hi, m_hi);
    chk("flush.lo", lo, m_lo);
    write_hilo(1, 0, 32'h0000_1234);

    // start and mthi while busy are both ignored.
    model(2'b01, 32'd3, 32'd4);
    start = 1'b1; op = 2'b01; op1 = 32'd3; op2 = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b11; op1 = 32'd100; op2 = 32'd0;
    mthi = 1'b1; wdata = 32'hDEAD;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0;
    chk("busy_start.hi_kept", hi, 32'h1234);
    k = 6;
    while (done !== 1'b1 && k < 80) begin
      @(negedge clock);
      k++;
    end
    chk("busy_start.latency", k, 33);
    chk("busy_start.hi", hi, m_hi);
    chk("busy_start.lo", lo, m_lo);
    chk("busy_start.dz", divide_zero, 0);
    @(negedge clock);
    chk("busy_start.idle", busy, 0);

    // start + mthi in IDLE: start wins, write dropped.
    start = 1'b1; op = 2'b11; op1 = 32'd100; op2 = 32'd7; mthi = 1'b1; wdata = 32'h777;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0;
    chk("start_wins.hi_kept", hi, m_hi);
    model(2'b11, 32'd100, 32'd7);
    finish_op("start_wins", 1'b0);

    // flush + start + mthi in IDLE: start dropped, write honoured.
    start = 1'b1; flush = 1'b1; mthi = 1'b1; op = 2'b01; wdata = 32'h55;
    @(negedge clock);
    start = 1'b0; flush = 1'b0; mthi = 1'b0;
    m_hi = 32'h55;
    chk("flush_start.busy", busy, 0);
    chk("flush_start.hi", hi, m_hi);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("flush_start.no_done", saw_done, 0);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom % 4);
      ra = $urandom;
      rb = ($urandom % 8 == 0) ? 32'd0 : $urandom;
      if ($urandom % 3 == 0) rb = rb % 16;
      if ($urandom % 4 == 0) ra = ra % 1000;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    // WIDTH=8 instance.
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
    @(negedge clock);
    start8 = 1'b0;
    k = 0;
    while (done8 !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("w8_mult.latency", k, 9);
    chk("w8_mult.hi", hi8, 8'h40);
    chk("w8_mult.lo", lo8, 8'h00);

    start8 = 1'b1; op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clock);
    start8 = 1'b0;
    repeat (4) @(negedge clock);
    chk("w8_run.busy", busy8, 1);
    #2 reset = 1'b0;
    #1;
    chk("w8_reset.busy", busy8, 0);
    chk("w8_reset.hi", hi8, 0);
    chk("w8_reset.lo", lo8, 0);
    chk("w8_reset.done", done8, 0);
    chk("w8_reset.dz", dz8, 0);
    chk("w32_reset.hi", hi, 0);
    chk("w32_reset.lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit that owns the HI/LO register pair for the execute stage of the multistage pipeline. It replaces single-cycle combinational multiply/divide with a radix-2 shift-add multiplier and a restoring divider sharing one datapath. A start/busy/done handshake lets the hazard unit stall HI/LO consumers, and a flush input aborts an in-flight operation on exception.

## Interface
- WIDTH, 32, operand width in bits; even, ≥ 4; HI and LO are each WIDTH bits.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op1  input  WIDTH  multiplicand / dividend (rs)
- op2  input  WIDTH  multiplier / divisor (rt)
- flush  input  1  abort in-flight operation
- mthi  input  1  write wdata to HI (IDLE only)
- mtlo  input  1  write wdata to LO (IDLE only)
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO results valid
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- divide_zero  output  1  last DIV/DIVU had op2 == 0; cleared by next accepted start

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, flush=0:
  - Latch op and sign flags (signed ops only).
  - Latch |op1| and |op2| (two's-complement magnitude, WIDTH-bit unsigned); unsigned ops latch raw values.
  - Clear divide_zero; load counter with WIDTH; go to RUN.
- DIV/DIVU with op2 == 0: skip RUN; next edge sets divide_zero=1 and pulses done. HI/LO unchanged; state stays IDLE.
- RUN multiply: 2·WIDTH-bit accumulator.
  - Each cycle, if multiplier LSB is set, add multiplicand to the upper half.
  - Shift the accumulator right 1 with carry-in.
- RUN divide: restoring division.
  - Each cycle, shift {rem, quo} left 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quo LSB.
- Counter decrements each RUN cycle; go to FIX when it reaches 1.
- FIX corrects signs, then writes HI/LO:
  - MULT: negate the 2·WIDTH product if signs differ; HI = upper half, LO = lower half.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign; HI = remainder, LO = quotient.
  - Then pulse done and return to IDLE.
- Signed overflow −2^(WIDTH−1) / −1: LO = 0x80…0, HI = 0. No flag raised.
- start while busy: ignored.
- mthi/mtlo while busy: ignored; the pipeline stalls instead.
- Same-cycle start and mthi/mtlo in IDLE: start wins; the write is dropped.
- mthi and mtlo together: both registers written.
- flush in RUN/FIX: next state IDLE, no done, HI/LO and divide_zero unchanged.
- flush with start in IDLE: start dropped; mthi/mtlo still honoured.
- Reset (any time, including mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, divide_zero=0.

## Timing
- Start accepted at edge 0.
  - busy=1 after edge 0 through the FIX cycle.
  - RUN occupies edges 1..WIDTH.
  - The FIX edge (WIDTH+1) updates HI/LO and sets done=1, busy=0.
- Latency: WIDTH+1 clocks from the start edge to done/results visible (33 for WIDTH=32). A new start is accepted in that same done cycle.
- Divide-by-zero: done and divide_zero are visible 1 clock after the start edge; busy stays 0.
- done is high exactly one cycle per completed operation.
- mthi/mtlo writes are visible 1 clock after the write edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 clocks after the start edge; busy high 33 cycles.
- MULT −3 × 5, i.e. 0xFFFFFFFD × 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5 / 0 with prior hi=0xAA, lo=0xBB -> divide_zero=1 and a done pulse 1 clock later; hi/lo unchanged. Next accepted start clears divide_zero.
- Flush and MTHI:
  - MULTU started, flush asserted in RUN cycle 10 -> busy=0 next clock, no done, hi/lo retain old values.
  - Then mthi with wdata=0x1234 -> hi=0x1234.
  - start asserted while busy is ignored.
- WIDTH=8 instance: MULT 0x80 × 0x80 -> hi=0x40, lo=0x00, done 9 clocks after start. A reset asserted mid-RUN clears all outputs immediately (asynchronously).
